// File: rtl/kt8_ctrl.sv
// KT8 sequencing controller: fetches opcode/operand bytes, drives A/B/R load
// enables and selects, the ALU function code and the zero/carry flags.
module kt8_ctrl #(
   parameter bit HALT_EN = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       instr_valid_i,
   input  logic [7:0] instr_i,
   output logic       instr_ready_o,
   input  logic [7:0] alu_res_i,
   input  logic       alu_cout_i,
   output logic [7:0] d_o,
   output logic       a_en_o,
   output logic       b_en_o,
   output logic       r_en_o,
   output logic       a_sel_o,
   output logic       b_sel_o,
   output logic [2:0] alu_op_o,
   output logic       z_o,
   output logic       c_o,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic       busy_o,
   output logic       halted_o
);

   // state | meaning
   // FETCH | waiting for an opcode byte
   // OPER  | waiting for the immediate operand of LDA/LDB
   // LOAD  | one cycle: load A or B from d_o
   // EXEC  | one cycle: load R from the ALU, update flags
   // XFER  | one cycle: load A or B from R
   // OUTW  | offering R to the consumer until it is taken
   // HALT  | stopped, only reset leaves
   typedef enum logic [2:0] {
      FETCH, OPER, LOAD, EXEC, XFER, OUTW, HALT
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] opc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= FETCH;
         opc      <= 3'd0;
         alu_op_o <= 3'd0;
         d_o      <= 8'h00;
         z_o      <= 1'b0;
         c_o      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == FETCH && instr_valid_i) begin
            opc      <= instr_i[7:5];
            alu_op_o <= instr_i[4:2];
         end
         if (state == OPER && instr_valid_i) begin
            d_o <= instr_i;
         end
         if (state == EXEC) begin
            z_o <= (alu_res_i == 8'h00);
            c_o <= alu_cout_i;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      instr_ready_o = 1'b0;
      a_en_o        = 1'b0;
      b_en_o        = 1'b0;
      r_en_o        = 1'b0;
      a_sel_o       = 1'b0;
      b_sel_o       = 1'b0;
      out_valid_o   = 1'b0;
      case (state)
         FETCH: begin
            instr_ready_o = 1'b1;
            if (instr_valid_i) begin
               case (instr_i[7:5])
                  3'b000, 3'b001: state_nxt = OPER;
                  3'b010:         state_nxt = EXEC;
                  3'b011, 3'b100: state_nxt = XFER;
                  3'b101:         state_nxt = OUTW;
                  3'b111:         state_nxt = HALT_EN ? HALT : FETCH;
                  default:        state_nxt = FETCH;
               endcase
            end
         end
         OPER: begin
            instr_ready_o = 1'b1;
            if (instr_valid_i) state_nxt = LOAD;
         end
         LOAD: begin
            a_en_o    = (opc == 3'b000);
            b_en_o    = (opc != 3'b000);
            state_nxt = FETCH;
         end
         EXEC: begin
            r_en_o    = 1'b1;
            state_nxt = FETCH;
         end
         XFER: begin
            a_en_o    = (opc == 3'b011);
            a_sel_o   = (opc == 3'b011);
            b_en_o    = (opc != 3'b011);
            b_sel_o   = (opc != 3'b011);
            state_nxt = FETCH;
         end
         OUTW: begin
            out_valid_o = 1'b1;
            if (out_ready_i) state_nxt = FETCH;
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
      // reset aborts whatever is in flight before any register is written
      if (rst_i) begin
         instr_ready_o = 1'b0;
         a_en_o        = 1'b0;
         b_en_o        = 1'b0;
         r_en_o        = 1'b0;
         a_sel_o       = 1'b0;
         b_sel_o       = 1'b0;
         out_valid_o   = 1'b0;
         state_nxt     = FETCH;
      end
   end

   assign busy_o   = (state != FETCH);
   assign halted_o = (state == HALT);

endmodule
